// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave with WAIT_STATES wait cycles and a one-cycle mem_ready strobe
//   clk, rst (sync, active-low), data_addr (byte address), data_in, mem_read, mem_write,
//   data_out (holds last read), mem_ready (completion strobe), busy (request outstanding),
//   mem_error (only with DMEM_ALIGN_CHECK_EN: misaligned or out-of-range access)
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           data_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  mem_ready,
  output logic                  busy
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic                  mem_error
`endif
);
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx_q, idx_in, r_idx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0] cnt;
  logic we_q, err_q, err_in, go, enter, r_we, r_err;
  assign idx_in = data_addr[ADDR_WIDTH+1:2];
  assign err_in = ALIGN && (data_addr[1:0] != 2'd0 || data_addr[31:ADDR_WIDTH+2] != '0);
  // RESP is entered either straight from capture (no wait states) or from the last WAIT cycle;
  // the r_* signals pick the live inputs or the latched request accordingly.
  always_comb begin
    go = state == IDLE && (mem_read || mem_write);
    enter = (go && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd1);
    r_idx = state == IDLE ? idx_in : idx_q;
    r_we = state == IDLE ? mem_write : we_q;
    r_err = state == IDLE ? err_in : err_q;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      data_out <= '0;
      mem_ready <= 1'b0;
      busy <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      mem_error <= 1'b0;
`endif
    end else begin
      mem_ready <= enter;
`ifdef DMEM_ALIGN_CHECK_EN
      mem_error <= enter && r_err;
`endif
      if (go) begin
        idx_q <= idx_in;
        wdata_q <= data_in;
        we_q <= mem_write;
        err_q <= err_in;
        cnt <= 4'(WAIT_STATES);
        busy <= 1'b1;
      end
      if (state == WAIT) cnt <= cnt - 4'd1;
      if (enter && !r_we) data_out <= r_err ? '0 : mem[r_idx];
      if (enter) state <= RESP;
      else if (go) state <= WAIT;
      else if (state == RESP) begin
        state <= IDLE;
        busy <= 1'b0;
      end
    end
  // Writes commit on the edge that ends RESP; a reset on that edge aborts them.
  always_ff @(posedge clk)
    if (rst && state == RESP && we_q && !err_q) mem[idx_q] <= wdata_q;
endmodule
